pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer side of the hazard/stall interface. Takes the load-use Stall from hazard detection,
//  the branch/jump flush request from EX, the data-memory busy flag and the halt request.
//  Drives per-stage write enables, flushes and bubble insertion for the 5-stage RV32IC pipeline.
//  Sits beside the pipeline registers. Also keeps saturating stall/flush statistics counters.
// PARAMETERS
//  FLUSH_LEN  2   cycles the fetch path stays squashed after a taken branch (>=1)
//  CNT_W      16  width of the statistics counters
// PORTS
//  clk            in   1      pipeline clock (single clock domain)
//  rst            in   1      synchronous, active-high reset
//  stall_req      in   1      load-use stall from hazard detection
//  flush_req      in   1      taken branch/jump resolved in EX; 1-cycle pulse
//  mem_busy       in   1      data memory not ready; level, held until access completes
//  halt_req       in   1      ecall/ebreak/fence retiring; 1-cycle pulse
//  pc_we          out  1      PC register write enable
//  if_id_we       out  1      IF/ID write enable
//  if_id_flush    out  1      zero IF/ID (insert NOP) on next edge
//  id_ex_we       out  1      ID/EX write enable
//  id_ex_bubble   out  1      load zeroed control into ID/EX on next edge
//  ex_mem_we      out  1      EX/MEM write enable
//  mem_wb_we      out  1      MEM/WB write enable
//  halted         out  1      core halted; high until rst
//  stall_cycles   out  CNT_W  count of cycles with stall_req honoured (saturating)
//  flush_events   out  CNT_W  count of accepted flushes (saturating)
// BEHAVIOUR
//  - Outputs are combinational (Mealy) from state+inputs: zero-cycle response. State/counters update on posedge clk.
//  - Reset: state=RUN, flush_cnt=0, pend_flush=0, counters=0, halted=0.
//    Reset outputs: all *_we=1, if_id_flush=0, id_ex_bubble=0. rst wins over every input, mid-FLUSH or mid-MEM_WAIT.
//  - Priority within a cycle: halt_req > mem_busy > flush_req > stall_req.
//  - RUN, idle: all we=1, no flush/bubble.
//  - RUN + stall_req: pc_we=0, if_id_we=0, id_ex_bubble=1, others we=1; stay RUN; stall_cycles++.
//  - RUN + flush_req: if_id_flush=1, id_ex_bubble=1, pc_we=1; flush_events++.
//    Same-cycle stall_req ignored (not counted). FLUSH_LEN>1 -> FLUSH with flush_cnt=FLUSH_LEN-1; else stay RUN.
//  - FLUSH: if_id_flush=1, pc_we=1; flush_cnt-- each cycle; ->RUN when flush_cnt==1 at edge.
//    stall_req ignored. A new flush_req reloads flush_cnt=FLUSH_LEN-1 and counts again.
//  - mem_busy (RUN or FLUSH): all we=0, no flush/bubble (full freeze) -> MEM_WAIT.
//    In FLUSH, flush_cnt is frozen and restored on exit.
//  - MEM_WAIT: all we=0 while mem_busy. flush_req seen here sets pend_flush (not applied yet).
//    When mem_busy=0: if pend_flush, act as RUN+flush_req (event counted then), clear it.
//    Else return to prior state (RUN/FLUSH).
//  - HALT (any state + halt_req): all we=0 from that cycle; halted=1 from next cycle; terminal until rst.
//  - Counters saturate at all-ones, never wrap.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg: state enum {RUN,FLUSH,MEM_WAIT,HALT} (2-bit) and stage-enable bundle field indices.
//  - Sub-module sat_counter #(W) instantiated twice for the statistics. Everything else in one always_ff + one always_comb.
// TESTING
//  1 rst high 3 cycles, all inputs 1 -> all we=1, flush/bubble=0, halted=0, counters=0 after release.
//  2 stall_req high 2 cycles in RUN -> pc_we=if_id_we=0, id_ex_bubble=1 both cycles; stall_cycles=2.
//  3 flush_req pulse, FLUSH_LEN=2 -> if_id_flush=1 for 2 cycles, id_ex_bubble=1 first only; back to RUN; flush_events=1.
//  4 mem_busy 4 cycles, flush_req in 2nd -> all we=0 for 4 cycles; then if_id_flush=1 on exit; flush_events=1.
//  5 halt_req with stall_req+flush_req same cycle -> all we=0, halted=1 next cycle; held 10 cycles; rst clears.
//  6 CNT_W=4, stall_req 20 cycles -> stall_cycles saturates at 15; rst mid-FLUSH returns RUN next edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: controller state and
// the indices of the stage write-enable bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam int WE_PC     = 0;
  localparam int WE_IF_ID  = 1;
  localparam int WE_ID_EX  = 2;
  localparam int WE_EX_MEM = 3;
  localparam int WE_MEM_WB = 4;
  localparam int NUM_WE    = 5;

  localparam logic [NUM_WE-1:0] WE_ALL   = 5'b11111;
  localparam logic [NUM_WE-1:0] WE_NONE  = 5'b00000;
  // Load-use stall holds PC and IF/ID, everything downstream keeps moving.
  localparam logic [NUM_WE-1:0] WE_STALL = 5'b11100;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: turns hazard, branch, memory
// and halt requests into per-stage write enables, flushes and bubbles.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_LEN - 1);

  state_e           state_q, state_d;
  state_e           prior_q, prior_d;
  state_e           eff_state;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic             pend_q, pend_d;
  logic             do_flush;
  logic [NUM_WE-1:0] we_vec;
  logic             flush_o, bubble_o;
  logic             stall_inc, flush_inc;

  always_comb begin
    state_d     = state_q;
    prior_d     = prior_q;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    we_vec      = WE_ALL;
    flush_o     = 1'b0;
    bubble_o    = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    eff_state   = state_q;
    do_flush    = flush_req;

    // Leaving MEM_WAIT behaves like the state we froze in, or like a fresh
    // flush if one arrived while frozen.
    if (state_q == ST_MEM_WAIT && !mem_busy) begin
      eff_state = pend_q ? ST_RUN : prior_q;
      do_flush  = flush_req | pend_q;
      pend_d    = 1'b0;
    end

    if (state_q == ST_HALT || halt_req) begin
      we_vec  = WE_NONE;
      state_d = ST_HALT;
    end else if (mem_busy) begin
      we_vec = WE_NONE;
      if (state_q != ST_MEM_WAIT) prior_d = state_q;
      if (flush_req) pend_d = 1'b1;
      state_d = ST_MEM_WAIT;
    end else if (do_flush) begin
      flush_o     = 1'b1;
      bubble_o    = 1'b1;
      flush_inc   = 1'b1;
      flush_cnt_d = FLUSH_RELOAD;
      state_d     = (FLUSH_LEN > 1) ? ST_FLUSH : ST_RUN;
    end else if (eff_state == ST_FLUSH) begin
      flush_o     = 1'b1;
      flush_cnt_d = flush_cnt_q - FCW'(1);
      state_d     = (flush_cnt_q == FCW'(1)) ? ST_RUN : ST_FLUSH;
    end else if (stall_req) begin
      we_vec    = WE_STALL;
      bubble_o  = 1'b1;
      stall_inc = 1'b1;
      state_d   = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end

    if (rst) begin
      we_vec   = WE_ALL;
      flush_o  = 1'b0;
      bubble_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      prior_q     <= ST_RUN;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prior_q     <= prior_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
    end
  end

  assign pc_we        = we_vec[WE_PC];
  assign if_id_we     = we_vec[WE_IF_ID];
  assign id_ex_we     = we_vec[WE_ID_EX];
  assign ex_mem_we    = we_vec[WE_EX_MEM];
  assign mem_wb_we    = we_vec[WE_MEM_WB];
  assign if_id_flush  = flush_o;
  assign id_ex_bubble = bubble_o;
  assign halted       = (state_q == ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_events)
  );

endmodule
